// File: rtl/sweep_stim_pkg.sv
// Shared types and digit decoding for the four-valued port-equivalence stimulus sweep.
package sweep_stim_pkg;

    localparam int unsigned MAX_WIDTH = 16;
    localparam int unsigned BUS_MAX_W = 2 * MAX_WIDTH;
    localparam int unsigned VEC_MAX_W = 4 * MAX_WIDTH;

    localparam logic [1:0] DIG_0 = 2'd0;
    localparam logic [1:0] DIG_1 = 2'd1;
    localparam logic [1:0] DIG_X = 2'd2;
    localparam logic [1:0] DIG_Z = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE0,
        ST_PRE1,
        ST_APPLY,
        ST_CHECK,
        ST_DONE
    } state_e;

    // Map one 2-bit digit code to its four-state bit value.
    function automatic logic decode_digit(input logic [1:0] code);
        logic v;
        case (code)
            DIG_0:   v = 1'b0;
            DIG_1:   v = 1'b1;
            DIG_X:   v = 1'bx;
            default: v = 1'bz;
        endcase
        return v;
    endfunction

    // Expand an index into {in1, in2}: bit k of the result is digit k counted from the LSD,
    // so the low 2*width bits are exactly {in1_out, in2_out}; digits beyond 2*width read 0.
    function automatic logic [BUS_MAX_W-1:0] vec_to_bus(input logic [VEC_MAX_W-1:0] idx,
                                                        input int unsigned width);
        logic [BUS_MAX_W-1:0] bits;
        bits = '0;
        for (int unsigned k = 0; k < BUS_MAX_W; k++) begin
            if (k < 2 * width) begin
                bits[k] = decode_digit(idx[2*k +: 2]);
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/sweep_stim_driver_if.sv
// Stimulus/check bundle between the sweep driver and the equivalence harness.
interface sweep_stim_driver_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned VEC_W = 4 * WIDTH;

    logic             start;
    logic             ok_in;
    logic [WIDTH-1:0] in1_out;
    logic [WIDTH-1:0] in2_out;
    logic             check_strobe;
    logic             busy;
    logic             done;
    logic [VEC_W-1:0] vec_index;
    logic [VEC_W:0]   fail_count;
    logic [VEC_W-1:0] first_fail_idx;
    logic             fail_seen;

    modport master (
        input  start,
        input  ok_in,
        output in1_out,
        output in2_out,
        output check_strobe,
        output busy,
        output done,
        output vec_index,
        output fail_count,
        output first_fail_idx,
        output fail_seen
    );

    modport slave (
        output start,
        output ok_in,
        input  in1_out,
        input  in2_out,
        input  check_strobe,
        input  busy,
        input  done,
        input  vec_index,
        input  fail_count,
        input  first_fail_idx,
        input  fail_seen
    );

endinterface

// File: rtl/sweep_phase_timer.sv
// Loadable down-counter; terminal count flags the last cycle of a phase.
module sweep_phase_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_tc_c
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_tc_c = (r_cnt == '0);

endmodule

// File: rtl/sweep_stim_driver.sv
// Clocked four-valued stimulus sweep: pre-toggle, apply, settle, strobe the comparator,
// and tally failures so a full sweep runs unattended.
module sweep_stim_driver
    import sweep_stim_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned PRE    = 10,
    parameter int unsigned SETTLE = 100
) (
    input  logic                clk,
    input  logic                rst,
    sweep_stim_driver_if.master bus
);

    localparam int unsigned VEC_W   = 4 * WIDTH;
    localparam int unsigned FC_W    = VEC_W + 1;
    localparam int unsigned TMR_MAX = (PRE > SETTLE) ? PRE : SETTLE;
    localparam int unsigned TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);

    if (PRE == 0 || SETTLE == 0) begin : g_bad_phase
        $error("sweep_stim_driver: PRE and SETTLE must both be nonzero");
    end
    if (WIDTH == 0 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("sweep_stim_driver: WIDTH out of supported range");
    end

    state_e             r_state;
    logic [WIDTH-1:0]   r_in1;
    logic [WIDTH-1:0]   r_in2;
    logic               r_check_strobe;
    logic               r_busy;
    logic               r_done;
    logic [VEC_W-1:0]   r_vec_index;
    logic [FC_W-1:0]    r_fail_count;
    logic [VEC_W-1:0]   r_first_fail;
    logic               r_fail_seen;

    logic               w_tmr_load;
    logic [TMR_W-1:0]   w_tmr_val;
    logic               w_tmr_tc;
    logic [BUS_MAX_W-1:0] w_bus_full;
    logic               w_bus_unused;
    logic [WIDTH-1:0]   w_in1;
    logic [WIDTH-1:0]   w_in2;

    // Decoded stimulus for the current index; digits above 2*WIDTH are always zero.
    assign w_bus_full   = vec_to_bus(VEC_MAX_W'(r_vec_index), WIDTH);
    assign w_bus_unused = ^w_bus_full;
    assign w_in1        = w_bus_full[2*WIDTH-1 -: WIDTH];
    assign w_in2        = w_bus_full[WIDTH-1:0];

    // Phase timer reloads on every state change with the length of the phase being entered.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_tmr_load = bus.start;
                w_tmr_val  = TMR_W'(PRE - 1);
            end
            ST_PRE0: begin
                w_tmr_load = w_tmr_tc;
                w_tmr_val  = TMR_W'(PRE - 1);
            end
            ST_PRE1: begin
                w_tmr_load = w_tmr_tc;
                w_tmr_val  = TMR_W'(SETTLE - 1);
            end
            ST_APPLY: begin
                w_tmr_load = w_tmr_tc;
            end
            ST_CHECK: begin
                w_tmr_load = 1'b1;
                w_tmr_val  = TMR_W'(PRE - 1);
            end
            default: begin
                w_tmr_load = 1'b0;
            end
        endcase
    end

    sweep_phase_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_tc_c     (w_tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_in1          <= '0;
            r_in2          <= '0;
            r_check_strobe <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_vec_index    <= '0;
            r_fail_count   <= '0;
            r_first_fail   <= '0;
            r_fail_seen    <= 1'b0;
        end else begin
            r_check_strobe <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_state      <= ST_PRE0;
                        r_vec_index  <= '0;
                        r_fail_count <= '0;
                        r_first_fail <= '0;
                        r_fail_seen  <= 1'b0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                    end
                end
                ST_PRE0: begin
                    if (w_tmr_tc) begin
                        r_state <= ST_PRE1;
                        r_in1   <= '1;
                        r_in2   <= '1;
                    end
                end
                ST_PRE1: begin
                    if (w_tmr_tc) begin
                        r_state <= ST_APPLY;
                        r_in1   <= w_in1;
                        r_in2   <= w_in2;
                    end
                end
                ST_APPLY: begin
                    if (w_tmr_tc) begin
                        r_state        <= ST_CHECK;
                        r_check_strobe <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    // Anything but a clean 1 (including X/Z) counts as a failure.
                    if (bus.ok_in !== 1'b1) begin
                        if (r_fail_count != '1) begin
                            r_fail_count <= r_fail_count + FC_W'(1);
                        end
                        if (!r_fail_seen) begin
                            r_first_fail <= r_vec_index;
                            r_fail_seen  <= 1'b1;
                        end
                    end
                    r_in1 <= '0;
                    r_in2 <= '0;
                    if (r_vec_index == '1) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state     <= ST_PRE0;
                        r_vec_index <= r_vec_index + VEC_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in1_out        = r_in1;
    assign bus.in2_out        = r_in2;
    assign bus.check_strobe   = r_check_strobe;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.vec_index      = r_vec_index;
    assign bus.fail_count     = r_fail_count;
    assign bus.first_fail_idx = r_first_fail;
    assign bus.fail_seen      = r_fail_seen;

endmodule

// File: tb/tb_sweep_stim_driver.sv
// Bench for sweep_stim_driver: reset, a cycle-offset vector table, directed failure
// patterns, mid-sweep reset, randomized ok_in/start, and a WIDTH=2 full-count run.
`timescale 1ns/1ps
module tb_sweep_stim_driver;

    localparam int unsigned W      = 1;
    localparam int unsigned PRE    = 2;
    localparam int unsigned SETTLE = 3;
    localparam int unsigned VW     = 4 * W;
    localparam int unsigned CPV    = 2 * PRE + SETTLE + 1;
    localparam int unsigned NVEC   = 1 << VW;
    localparam int unsigned TOTAL  = NVEC * CPV;

    localparam int unsigned W2      = 2;
    localparam int unsigned PRE2    = 1;
    localparam int unsigned SETTLE2 = 1;
    localparam int unsigned CPV2    = 2 * PRE2 + SETTLE2 + 1;
    localparam int unsigned NVEC2   = 1 << (4 * W2);
    localparam int unsigned TOTAL2  = NVEC2 * CPV2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sweep_stim_driver_if #(.WIDTH(W))  bus1();
    sweep_stim_driver_if #(.WIDTH(W2)) bus2();

    sweep_stim_driver #(.WIDTH(W), .PRE(PRE), .SETTLE(SETTLE)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    sweep_stim_driver #(.WIDTH(W2), .PRE(PRE2), .SETTLE(SETTLE2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int n_err = 0;
    int n_chk = 0;
    int unsigned fails[$];

    typedef struct {
        int unsigned n;
        logic        strobe;
        logic        busy;
        logic        done;
        logic [3:0]  vec;
        logic        in1;
        logic        in2;
        logic        in1_k;
        logic        in2_k;
    } vec_row_t;

    localparam int NTAB = 13;
    vec_row_t tab[NTAB];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic pick_ok(input int mode, input int unsigned v);
        logic        r;
        int unsigned k;
        k = $urandom_range(0, 9);
        case (mode)
            0:       r = 1'b1;
            1:       r = (v == 5) ? 1'bx : 1'b1;
            2:       r = 1'b0;
            default: r = (k == 0) ? 1'b0 : ((k == 1) ? 1'bx : 1'b1);
        endcase
        return r;
    endfunction

    task automatic check_reset1(input string tag);
        chk({tag, "_in1"},    64'(bus1.in1_out), 64'(0));
        chk({tag, "_in2"},    64'(bus1.in2_out), 64'(0));
        chk({tag, "_strobe"}, 64'(bus1.check_strobe), 64'(0));
        chk({tag, "_busy"},   64'(bus1.busy), 64'(0));
        chk({tag, "_done"},   64'(bus1.done), 64'(0));
        chk({tag, "_vec"},    64'(bus1.vec_index), 64'(0));
        chk({tag, "_fcnt"},   64'(bus1.fail_count), 64'(0));
        chk({tag, "_first"},  64'(bus1.first_fail_idx), 64'(0));
        chk({tag, "_seen"},   64'(bus1.fail_seen), 64'(0));
    endtask

    // Expected DUT outputs n edges after the start-accept edge, from cycle arithmetic.
    task automatic check_model(input int unsigned n, input string tag);
        logic          e_strobe, e_busy, e_done;
        logic [VW-1:0] e_vec;
        logic [W-1:0]  e1, e2, m1, m2;
        int unsigned   v, p, c1, c2;
        e1 = '0; e2 = '0; m1 = '1; m2 = '1;
        if (n >= TOTAL) begin
            e_strobe = 1'b0; e_busy = 1'b0; e_done = 1'b1; e_vec = VW'(NVEC - 1);
        end else begin
            v = n / CPV;
            p = n % CPV;
            e_busy = 1'b1; e_done = 1'b0; e_vec = VW'(v);
            e_strobe = (p == CPV - 1);
            if (p >= PRE && p < 2 * PRE) begin
                e1 = '1; e2 = '1;
            end else if (p >= 2 * PRE) begin
                for (int j = 0; j < W; j++) begin
                    c2 = (v >> (2 * j)) & 3;
                    c1 = (v >> (2 * (W + j))) & 3;
                    m2[j] = (c2 < 2); e2[j] = (c2 == 1);
                    m1[j] = (c1 < 2); e1[j] = (c1 == 1);
                end
            end
        end
        chk($sformatf("%s_n%0d_strobe", tag, n), 64'(bus1.check_strobe), 64'(e_strobe));
        chk($sformatf("%s_n%0d_busy", tag, n),   64'(bus1.busy), 64'(e_busy));
        chk($sformatf("%s_n%0d_done", tag, n),   64'(bus1.done), 64'(e_done));
        chk($sformatf("%s_n%0d_vec", tag, n),    64'(bus1.vec_index), 64'(e_vec));
        chk($sformatf("%s_n%0d_in1", tag, n),    64'(bus1.in1_out & m1), 64'(e1 & m1));
        chk($sformatf("%s_n%0d_in2", tag, n),    64'(bus1.in2_out & m2), 64'(e2 & m2));
        chk($sformatf("%s_n%0d_fcnt", tag, n),   64'(bus1.fail_count), 64'(fails.size()));
        chk($sformatf("%s_n%0d_seen", tag, n),   64'(bus1.fail_seen), 64'(fails.size() > 0));
        chk($sformatf("%s_n%0d_first", tag, n),  64'(bus1.first_fail_idx),
            64'((fails.size() > 0) ? fails[0] : 0));
    endtask

    // One full sweep on the WIDTH=1 instance; abort_at >= 0 asserts rst during that cycle.
    task automatic run_sweep(input int mode, input int abort_at, input string tag);
        logic ok_prev;
        int   strobes;
        strobes = 0;
        fails.delete();
        bus1.start = 1'b1;
        bus1.ok_in = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        for (int unsigned n = 0; n <= TOTAL + 3; n++) begin
            if (n > 0 && n <= TOTAL && (n % CPV) == 0 && ok_prev !== 1'b1) begin
                fails.push_back(n / CPV - 1);
            end
            check_model(n, tag);
            if (bus1.check_strobe === 1'b1) strobes++;
            if (mode == 0) begin
                for (int i = 0; i < NTAB; i++) begin
                    if (tab[i].n == n) begin
                        chk($sformatf("tab%0d_strobe", i), 64'(bus1.check_strobe), 64'(tab[i].strobe));
                        chk($sformatf("tab%0d_busy", i),   64'(bus1.busy), 64'(tab[i].busy));
                        chk($sformatf("tab%0d_done", i),   64'(bus1.done), 64'(tab[i].done));
                        chk($sformatf("tab%0d_vec", i),    64'(bus1.vec_index), 64'(tab[i].vec));
                        if (tab[i].in1_k) chk($sformatf("tab%0d_in1", i), 64'(bus1.in1_out), 64'(tab[i].in1));
                        if (tab[i].in2_k) chk($sformatf("tab%0d_in2", i), 64'(bus1.in2_out), 64'(tab[i].in2));
                    end
                end
            end
            if (abort_at >= 0 && n == int'(abort_at)) begin
                bus1.ok_in = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                check_reset1({tag, "_rst_at_check"});
                rst = 1'b0;
                @(posedge clk); #1;
                chk({tag, "_idle_busy"}, 64'(bus1.busy), 64'(0));
                chk({tag, "_idle_done"}, 64'(bus1.done), 64'(0));
                chk({tag, "_idle_fcnt"}, 64'(bus1.fail_count), 64'(0));
                return;
            end
            ok_prev    = pick_ok(mode, (n < TOTAL) ? n / CPV : NVEC);
            bus1.ok_in = ok_prev;
            if (mode == 2)      bus1.start = (n >= 20 && n <= 40);
            else if (mode == 3) bus1.start = (n + 1 < TOTAL) ? 1'($urandom_range(0, 1)) : 1'b0;
            else                bus1.start = 1'b0;
            @(posedge clk); #1;
        end
        bus1.start = 1'b0;
        if (mode == 0) chk({tag, "_strobe_count"}, 64'(strobes), 64'(NVEC));
    endtask

    initial begin
        logic xv;
        xv = 1'bx;
        tab[0]  = '{0,   1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1};
        tab[1]  = '{2,   1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b1};
        tab[2]  = '{4,   1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1};
        tab[3]  = '{7,   1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1};
        tab[4]  = '{8,   1'b0, 1'b1, 1'b0, 4'd1,  1'b0, 1'b0, 1'b1, 1'b1};
        tab[5]  = '{15,  1'b1, 1'b1, 1'b0, 4'd1,  1'b0, 1'b1, 1'b1, 1'b1};
        tab[6]  = '{47,  1'b1, 1'b1, 1'b0, 4'd5,  1'b1, 1'b1, 1'b1, 1'b1};
        tab[7]  = '{48,  1'b0, 1'b1, 1'b0, 4'd6,  1'b0, 1'b0, 1'b1, 1'b1};
        tab[8]  = '{50,  1'b0, 1'b1, 1'b0, 4'd6,  1'b1, 1'b1, 1'b1, 1'b1};
        tab[9]  = '{55,  1'b1, 1'b1, 1'b0, 4'd6,  1'b1, 1'b0, 1'b1, 1'b0};
        tab[10] = '{79,  1'b1, 1'b1, 1'b0, 4'd9,  1'b0, 1'b1, 1'b0, 1'b1};
        tab[11] = '{127, 1'b1, 1'b1, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[12] = '{128, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset held two cycles with start asserted.
        rst = 1'b1;
        bus1.start = 1'b1; bus1.ok_in = 1'b1;
        bus2.start = 1'b1; bus2.ok_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset1("reset");
        chk("reset2_busy", 64'(bus2.busy), 64'(0));
        chk("reset2_fcnt", 64'(bus2.fail_count), 64'(0));
        rst = 1'b0;
        bus1.start = 1'b0; bus2.start = 1'b0;
        @(posedge clk); #1;
        check_reset1("idle");

        run_sweep(0, -1, "pass");
        run_sweep(1, -1, "xat5");
        chk("xat5_fcnt",  64'(bus1.fail_count),     64'((xv !== 1'b1) ? 1 : 0));
        chk("xat5_first", 64'(bus1.first_fail_idx), 64'((xv !== 1'b1) ? 5 : 0));
        chk("xat5_seen",  64'(bus1.fail_seen),      64'((xv !== 1'b1) ? 1 : 0));
        run_sweep(2, -1, "allfail");
        chk("allfail_fcnt",  64'(bus1.fail_count),     64'(16));
        chk("allfail_first", 64'(bus1.first_fail_idx), 64'(0));
        chk("allfail_seen",  64'(bus1.fail_seen),      64'(1));
        run_sweep(2, 7, "restart_abort");
        run_sweep(3, -1, "rand_a");
        run_sweep(3, -1, "rand_b");

        // WIDTH=2, minimal phases: every one of 256 vectors fails, count must not saturate.
        bus2.ok_in = 1'b0;
        bus2.start = 1'b1;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        chk("w2_busy_start", 64'(bus2.busy), 64'(1));
        for (int unsigned n = 1; n <= TOTAL2; n++) begin
            @(posedge clk); #1;
            if (n == TOTAL2 - 1) begin
                chk("w2_done_early", 64'(bus2.done), 64'(0));
                chk("w2_fcnt_early", 64'(bus2.fail_count), 64'(NVEC2 - 1));
            end
        end
        chk("w2_done",  64'(bus2.done),           64'(1));
        chk("w2_busy",  64'(bus2.busy),           64'(0));
        chk("w2_fcnt",  64'(bus2.fail_count),     64'(256));
        chk("w2_first", 64'(bus2.first_fail_idx), 64'(0));
        chk("w2_seen",  64'(bus2.fail_seen),      64'(1));
        chk("w2_vec",   64'(bus2.vec_index),      64'(255));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
